// File: rtl/rx_chan_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rx_chan_arbiter_pkg
// Shared definitions for the RX channel arbiter slice:
//   - arb_state_t    : arbiter FSM state encoding
//   - chan_t         : channel identifiers (CH_09 = 0, CH_24 = 1)
//   - WORD_W         : FIFO word width in bits
//   - BYTES_PER_WORD : bytes serialized per FIFO word
//   - other_chan()   : returns the opposite channel
// ---------------------------------------------------------------------------
package rx_chan_arbiter_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PULL    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_NEXT    = 3'd4
    } arb_state_t;

    typedef enum logic {
        CH_09 = 1'b0,
        CH_24 = 1'b1
    } chan_t;

    function automatic chan_t other_chan(input chan_t ch);
        return (ch == CH_09) ? CH_24 : CH_09;
    endfunction

endpackage

// File: rtl/rx_chan_arbiter_ovf_counter.sv
// ---------------------------------------------------------------------------
// ovf_counter
// Counts rising edges of a FIFO-full flag while the channel is enabled.
// The count saturates at all-ones and is zeroed by a synchronous clear;
// a clear in the same cycle as an edge leaves the count at zero.
// Ports:
//   clk    : system clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   enable : channel enable; edges are ignored while low
//   clear  : synchronous clear of the count
//   full   : FIFO full flag
//   count  : saturating event count
// ---------------------------------------------------------------------------
module ovf_counter
    import rx_chan_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             full,
    output logic [CNT_W-1:0] count
);

    logic full_prev;
    logic full_rise;

    assign full_rise = full & ~full_prev;

    // The previous-value register tracks the flag even while disabled so
    // that re-enabling with full already high does not fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_prev <= 1'b0;
            count     <= '0;
        end else begin
            full_prev <= full;
            if (clear) begin
                count <= '0;
            end else if (enable && full_rise && (count != '1)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_chan_arbiter.sv
// ---------------------------------------------------------------------------
// rx_chan_arbiter
// Merges the 900 MHz and 2.4 GHz RX sample FIFOs into one byte stream for
// the SMI read path. Each 32-bit word is popped, then sent MS byte first as
// 4 bytes tagged with the source channel. Channels are served round-robin
// with at most BURST_LEN consecutive words while the other one is waiting.
// Ports:
//   i_sys_clk, i_rst_b              : clock, async active-low reset
//   i_enable_09, i_enable_24        : channel enables
//   i_clear_stats                   : synchronous clear of overflow counts
//   i_fifo_<ch>_empty/_full/_data   : FIFO read-port status and data
//   o_fifo_<ch>_pull                : 1-cycle FIFO read strobe
//   o_byte_data/_valid/_chan/_first : byte stream towards the SMI sink
//   i_byte_ready                    : sink handshake
//   o_ovf_09, o_ovf_24              : FIFO-full event counts
//   o_busy                          : FSM not idle
// ---------------------------------------------------------------------------
module rx_chan_arbiter
    import rx_chan_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_b,
    input  logic              i_enable_09,
    input  logic              i_enable_24,
    input  logic              i_clear_stats,
    input  logic              i_fifo_09_empty,
    input  logic              i_fifo_09_full,
    input  logic [WORD_W-1:0] i_fifo_09_data,
    output logic              o_fifo_09_pull,
    input  logic              i_fifo_24_empty,
    input  logic              i_fifo_24_full,
    input  logic [WORD_W-1:0] i_fifo_24_data,
    output logic              o_fifo_24_pull,
    output logic [7:0]        o_byte_data,
    output logic              o_byte_valid,
    input  logic              i_byte_ready,
    output logic              o_byte_chan,
    output logic              o_byte_first,
    output logic [CNT_W-1:0]  o_ovf_09,
    output logic [CNT_W-1:0]  o_ovf_24,
    output logic              o_busy
);

    localparam int                BC_W      = $clog2(BURST_LEN + 1);
    localparam logic [BC_W-1:0]   BURST_MAX = BC_W'(BURST_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

    arb_state_t        state, state_next;
    chan_t             cur_chan, cur_chan_next;
    chan_t             last_grant, last_grant_next;
    chan_t             other_ch;
    logic [BC_W-1:0]   burst_cnt, burst_cnt_next, burst_inc;
    logic [WORD_W-1:0] word, word_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [1:0]        elig;
    logic [WORD_W-1:0] cap_data;

    // elig[0] is channel 09, elig[1] is channel 24, so it indexes by chan_t.
    assign elig     = {i_enable_24 & ~i_fifo_24_empty, i_enable_09 & ~i_fifo_09_empty};
    assign other_ch = other_chan(cur_chan);
    assign cap_data = (cur_chan == CH_09) ? i_fifo_09_data : i_fifo_24_data;

    // Burst count including the word just finished; held at BURST_LEN so a
    // channel streaming alone cannot wrap the counter.
    assign burst_inc = (burst_cnt >= BURST_MAX) ? burst_cnt : burst_cnt + BC_W'(1);

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state      <= ST_IDLE;
            cur_chan   <= CH_09;
            last_grant <= CH_24;
            burst_cnt  <= '0;
            word       <= '0;
            idx        <= '0;
        end else begin
            state      <= state_next;
            cur_chan   <= cur_chan_next;
            last_grant <= last_grant_next;
            burst_cnt  <= burst_cnt_next;
            word       <= word_next;
            idx        <= idx_next;
        end
    end

    always_comb begin
        state_next      = state;
        cur_chan_next   = cur_chan;
        last_grant_next = last_grant;
        burst_cnt_next  = burst_cnt;
        word_next       = word;
        idx_next        = idx;

        case (state)
            ST_IDLE: begin
                burst_cnt_next = '0;
                if (elig[CH_09] && elig[CH_24]) begin
                    cur_chan_next = other_chan(last_grant);
                    state_next    = ST_PULL;
                end else if (elig[CH_09]) begin
                    cur_chan_next = CH_09;
                    state_next    = ST_PULL;
                end else if (elig[CH_24]) begin
                    cur_chan_next = CH_24;
                    state_next    = ST_PULL;
                end
            end

            ST_PULL: begin
                state_next = ST_CAPTURE;
            end

            // FIFO read data is valid the cycle after the pull strobe.
            ST_CAPTURE: begin
                word_next  = cap_data;
                idx_next   = LAST_IDX;
                state_next = ST_SEND;
            end

            ST_SEND: begin
                if (i_byte_ready) begin
                    if (idx == '0) begin
                        state_next = ST_NEXT;
                    end else begin
                        idx_next = idx - IDX_W'(1);
                    end
                end
            end

            // Enables and empty flags are re-sampled here, so a channel
            // disabled mid-word finishes its word but is not pulled again.
            ST_NEXT: begin
                if (elig[cur_chan] && ((burst_inc < BURST_MAX) || !elig[other_ch])) begin
                    burst_cnt_next = burst_inc;
                    state_next     = ST_PULL;
                end else if (elig[other_ch]) begin
                    cur_chan_next   = other_ch;
                    last_grant_next = other_ch;
                    burst_cnt_next  = '0;
                    state_next      = ST_PULL;
                end else begin
                    burst_cnt_next = '0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Byte-path outputs are gated by valid so they read zero outside SEND.
    assign o_byte_valid   = (state == ST_SEND);
    assign o_byte_data    = o_byte_valid ? word[{idx, 3'b000} +: 8] : 8'h00;
    assign o_byte_first   = o_byte_valid && (idx == LAST_IDX);
    assign o_byte_chan    = o_byte_valid && (cur_chan == CH_24);
    assign o_fifo_09_pull = (state == ST_PULL) && (cur_chan == CH_09);
    assign o_fifo_24_pull = (state == ST_PULL) && (cur_chan == CH_24);
    assign o_busy         = (state != ST_IDLE);

    ovf_counter #(
        .CNT_W(CNT_W)
    ) u_ovf_09 (
        .clk   (i_sys_clk),
        .rst_n (i_rst_b),
        .enable(i_enable_09),
        .clear (i_clear_stats),
        .full  (i_fifo_09_full),
        .count (o_ovf_09)
    );

    ovf_counter #(
        .CNT_W(CNT_W)
    ) u_ovf_24 (
        .clk   (i_sys_clk),
        .rst_n (i_rst_b),
        .enable(i_enable_24),
        .clear (i_clear_stats),
        .full  (i_fifo_24_full),
        .count (o_ovf_24)
    );

endmodule

// File: tb/tb_rx_chan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rx_chan_arbiter
// Directed bench for rx_chan_arbiter. Two behavioural FIFOs feed the DUT;
// a negedge monitor records every accepted byte and every pull strobe.
// Each scenario task drives its stimulus and compares against
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_rx_chan_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        enable_09, enable_24, clear_stats;
    logic        fifo_09_empty, fifo_09_full, fifo_09_pull;
    logic        fifo_24_empty, fifo_24_full, fifo_24_pull;
    logic [31:0] fifo_09_data = '0;
    logic [31:0] fifo_24_data = '0;
    logic [7:0]  byte_data;
    logic        byte_valid, byte_ready, byte_chan, byte_first, busy;
    logic [7:0]  ovf_09, ovf_24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_chan_arbiter #(
        .BURST_LEN(4),
        .CNT_W    (8)
    ) dut (
        .i_sys_clk      (clk),
        .i_rst_b        (rst_b),
        .i_enable_09    (enable_09),
        .i_enable_24    (enable_24),
        .i_clear_stats  (clear_stats),
        .i_fifo_09_empty(fifo_09_empty),
        .i_fifo_09_full (fifo_09_full),
        .i_fifo_09_data (fifo_09_data),
        .o_fifo_09_pull (fifo_09_pull),
        .i_fifo_24_empty(fifo_24_empty),
        .i_fifo_24_full (fifo_24_full),
        .i_fifo_24_data (fifo_24_data),
        .o_fifo_24_pull (fifo_24_pull),
        .o_byte_data    (byte_data),
        .o_byte_valid   (byte_valid),
        .i_byte_ready   (byte_ready),
        .o_byte_chan    (byte_chan),
        .o_byte_first   (byte_first),
        .o_ovf_09       (ovf_09),
        .o_ovf_24       (ovf_24),
        .o_busy         (busy)
    );

    // Behavioural FIFOs: tasks append at wr, the pull strobe pops at rd and
    // presents the word on the data port the following cycle.
    logic [31:0] mem_09 [0:63];
    logic [31:0] mem_24 [0:63];
    int wr_09 = 0, rd_09 = 0, wr_24 = 0, rd_24 = 0;

    assign fifo_09_empty = (rd_09 == wr_09);
    assign fifo_24_empty = (rd_24 == wr_24);

    always @(posedge clk) begin
        if (fifo_09_pull && (rd_09 < wr_09)) begin
            fifo_09_data <= mem_09[rd_09];
            rd_09        <= rd_09 + 1;
        end
        if (fifo_24_pull && (rd_24 < wr_24)) begin
            fifo_24_data <= mem_24[rd_24];
            rd_24        <= rd_24 + 1;
        end
    end

    // Monitor: a byte seen valid & ready at negedge is accepted at the next
    // posedge; cyc stamps let tasks verify back-to-back delivery.
    logic [7:0] got_data [$];
    logic       got_chan [$];
    logic       got_first[$];
    int         got_cyc  [$];
    int cyc = 0;
    int pulls_09 = 0, pulls_24 = 0, empty_pulls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid && byte_ready) begin
            got_data.push_back(byte_data);
            got_chan.push_back(byte_chan);
            got_first.push_back(byte_first);
            got_cyc.push_back(cyc);
        end
        if (fifo_09_pull) pulls_09 = pulls_09 + 1;
        if (fifo_24_pull) pulls_24 = pulls_24 + 1;
        if ((fifo_09_pull && fifo_09_empty) || (fifo_24_pull && fifo_24_empty))
            empty_pulls = empty_pulls + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_09(input logic [31:0] w);
        mem_09[wr_09] = w;
        wr_09 = wr_09 + 1;
    endtask

    task automatic push_24(input logic [31:0] w);
        mem_24[wr_24] = w;
        wr_24 = wr_24 + 1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; enable_09 = 1'b0; enable_24 = 1'b0; clear_stats = 1'b0;
        fifo_09_full = 1'b0; fifo_24_full = 1'b0; byte_ready = 1'b0;
        tick(3);
        rst_b = 1'b1;
        tick(2);
        checks++;
        if ({byte_valid, byte_first, byte_chan, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {byte_valid, byte_first, byte_chan, busy});
        end
        checks++;
        if ({fifo_09_pull, fifo_24_pull} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_pull: got %b expected 00", {fifo_09_pull, fifo_24_pull});
        end
        checks++;
        if ({byte_data, ovf_09, ovf_24} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 000000", {byte_data, ovf_09, ovf_24});
        end
    endtask

    task automatic test_single_word();
        int base, p09, n;
        logic [9:0] exp_b [4];
        exp_b = '{{8'hA1, 1'b0, 1'b1}, {8'hB2, 1'b0, 1'b0}, {8'hC3, 1'b0, 1'b0}, {8'hD4, 1'b0, 1'b0}};
        base = got_data.size();
        p09  = pulls_09;
        byte_ready = 1'b1;
        push_09(32'hA1B2C3D4);
        enable_09 = 1'b1;
        n = 0;
        while (!byte_valid && n < 10) begin
            tick(1);
            n++;
        end
        checks++;
        if (!byte_valid || n > 3) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d cycles expected <= 3", n);
        end
        tick(10);
        checks++;
        if (got_data.size() - base !== 4) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d bytes expected 4", got_data.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({got_data[base+i], got_chan[base+i], got_first[base+i]} !== exp_b[i]) begin
                    errors++;
                    $display("[TB] FAIL single_byte%0d: got %h expected %h", i,
                             {got_data[base+i], got_chan[base+i], got_first[base+i]}, exp_b[i]);
                end
            end
            checks++;
            if (got_cyc[base+3] - got_cyc[base] !== 3) begin
                errors++;
                $display("[TB] FAIL single_gapless: got span %0d expected 3", got_cyc[base+3] - got_cyc[base]);
            end
        end
        checks++;
        if ({pulls_09 - p09, 31'(busy)} !== {32'd1, 31'd0}) begin
            errors++;
            $display("[TB] FAIL single_pulls_idle: got pulls %0d busy %b expected 1 0", pulls_09 - p09, busy);
        end
        enable_09 = 1'b0;
    endtask

    task automatic test_round_robin();
        int base, p09, p24, n, k09, k24;
        int exp_order [20] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};
        logic [31:0] exp_w, got_w;
        logic [3:0]  got_c, got_f;
        logic        exp_c;
        base = got_data.size();
        p09 = pulls_09; p24 = pulls_24;
        for (int i = 0; i < 10; i++) begin
            push_09(32'h0900_0000 + 32'(i));
            push_24(32'h2400_0000 + 32'(i));
        end
        byte_ready = 1'b1;
        enable_09 = 1'b1; enable_24 = 1'b1;
        n = 0;
        while (!((got_data.size() - base >= 80) && !busy) && n < 600) begin
            tick(1);
            n++;
        end
        checks++;
        if (got_data.size() - base !== 80 || busy) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d bytes busy %b expected 80 bytes idle", got_data.size() - base, busy);
        end
        k09 = 0; k24 = 0;
        for (int w = 0; w < 20; w++) begin
            if (base + 4*w + 3 < got_data.size()) begin
                exp_c = exp_order[w][0];
                exp_w = exp_c ? (32'h2400_0000 + 32'(k24)) : (32'h0900_0000 + 32'(k09));
                if (exp_c) k24++; else k09++;
                got_w = {got_data[base+4*w], got_data[base+4*w+1], got_data[base+4*w+2], got_data[base+4*w+3]};
                got_c = {got_chan[base+4*w], got_chan[base+4*w+1], got_chan[base+4*w+2], got_chan[base+4*w+3]};
                got_f = {got_first[base+4*w], got_first[base+4*w+1], got_first[base+4*w+2], got_first[base+4*w+3]};
                checks++;
                if ({got_c, got_f, got_w} !== {{4{exp_c}}, 4'b1000, exp_w}) begin
                    errors++;
                    $display("[TB] FAIL rr_word%0d: got chan %b first %b data %h expected chan %b first 1000 data %h",
                             w, got_c, got_f, got_w, {4{exp_c}}, exp_w);
                end
            end
        end
        checks++;
        if ({pulls_09 - p09, pulls_24 - p24, empty_pulls} !== {32'd10, 32'd10, 32'd0}) begin
            errors++;
            $display("[TB] FAIL rr_pulls: got %0d %0d empty %0d expected 10 10 0", pulls_09 - p09, pulls_24 - p24, empty_pulls);
        end
        enable_09 = 1'b0; enable_24 = 1'b0;
    endtask

    task automatic test_ready_toggle();
        int base, n, unstable;
        logic pat [12] = '{1,0,0,1,0,1,0,0,1,1,1,1};
        logic       prev_valid, prev_ready, prev_first;
        logic [7:0] prev_data;
        logic [31:0] got_w;
        base = got_data.size();
        byte_ready = 1'b0;
        push_09(32'h11223344);
        enable_09 = 1'b1;
        n = 0;
        while (!byte_valid && n < 10) begin
            tick(1);
            n++;
        end
        prev_valid = 1'b0; prev_ready = 1'b0; prev_first = 1'b0; prev_data = '0;
        unstable = 0;
        for (int i = 0; i < 12; i++) begin
            byte_ready = pat[i];
            @(negedge clk);
            if (prev_valid && !prev_ready &&
                (!byte_valid || byte_data !== prev_data || byte_first !== prev_first))
                unstable++;
            prev_valid = byte_valid; prev_ready = byte_ready;
            prev_data = byte_data; prev_first = byte_first;
            @(posedge clk);
            #1;
        end
        byte_ready = 1'b1;
        tick(5);
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("[TB] FAIL toggle_hold: got %0d unstable cycles expected 0", unstable);
        end
        checks++;
        if (got_data.size() - base !== 4) begin
            errors++;
            $display("[TB] FAIL toggle_count: got %0d bytes expected 4", got_data.size() - base);
        end else begin
            got_w = {got_data[base], got_data[base+1], got_data[base+2], got_data[base+3]};
            checks++;
            if (got_w !== 32'h11223344) begin
                errors++;
                $display("[TB] FAIL toggle_data: got %h expected 11223344", got_w);
            end
        end
        enable_09 = 1'b0;
    endtask

    task automatic test_enable_drop();
        int base, p24, n;
        logic [31:0] got_w;
        logic [3:0]  got_c;
        base = got_data.size();
        p24  = pulls_24;
        byte_ready = 1'b1;
        push_24(32'hCAFEBABE);
        push_24(32'h12345678);
        enable_24 = 1'b1;
        n = 0;
        while (got_data.size() - base < 2 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        enable_24 = 1'b0;
        tick(10);
        checks++;
        if (got_data.size() - base !== 4) begin
            errors++;
            $display("[TB] FAIL drop_count: got %0d bytes expected 4", got_data.size() - base);
        end else begin
            got_w = {got_data[base], got_data[base+1], got_data[base+2], got_data[base+3]};
            got_c = {got_chan[base], got_chan[base+1], got_chan[base+2], got_chan[base+3]};
            checks++;
            if ({got_c, got_w} !== {4'b1111, 32'hCAFEBABE}) begin
                errors++;
                $display("[TB] FAIL drop_data: got chan %b data %h expected 1111 cafebabe", got_c, got_w);
            end
        end
        checks++;
        if (pulls_24 - p24 !== 1 || busy) begin
            errors++;
            $display("[TB] FAIL drop_pulls: got %0d pulls busy %b expected 1 pull idle", pulls_24 - p24, busy);
        end
    endtask

    task automatic test_overflow();
        enable_09 = 1'b1; enable_24 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            fifo_09_full = 1'b1;
            fifo_24_full = (i < 3);
            tick(1);
            fifo_09_full = 1'b0;
            fifo_24_full = 1'b0;
            tick(1);
        end
        checks++;
        if (ovf_09 !== 8'd255) begin
            errors++;
            $display("[TB] FAIL ovf_saturate: got %0d expected 255", ovf_09);
        end
        checks++;
        if (ovf_24 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL ovf_disabled: got %0d expected 0", ovf_24);
        end
        fifo_09_full = 1'b1; clear_stats = 1'b1;
        tick(1);
        clear_stats = 1'b0;
        tick(1);
        checks++;
        if (ovf_09 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL ovf_clear_wins: got %0d expected 0", ovf_09);
        end
        fifo_09_full = 1'b0;
        tick(1);
        fifo_09_full = 1'b1;
        tick(1);
        checks++;
        if (ovf_09 !== 8'd1) begin
            errors++;
            $display("[TB] FAIL ovf_after_clear: got %0d expected 1", ovf_09);
        end
        fifo_09_full = 1'b0;
        enable_09 = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_send();
        int base, n;
        byte_ready = 1'b0;
        push_09(32'h55667788);
        enable_09 = 1'b1;
        n = 0;
        while (!byte_valid && n < 10) begin
            tick(1);
            n++;
        end
        checks++;
        if (!byte_valid) begin
            errors++;
            $display("[TB] FAIL rst_pre_valid: got valid %b expected 1", byte_valid);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if ({byte_valid, byte_first, byte_chan, busy, fifo_09_pull, fifo_24_pull} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL rst_async_ctrl: got %b expected 000000",
                     {byte_valid, byte_first, byte_chan, busy, fifo_09_pull, fifo_24_pull});
        end
        checks++;
        if ({byte_data, ovf_09, ovf_24} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL rst_async_data: got %h expected 000000", {byte_data, ovf_09, ovf_24});
        end
        enable_09 = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        tick(1);
        base = got_data.size();
        push_09(32'h99AABBCC);
        push_24(32'hDDEEFF00);
        byte_ready = 1'b1;
        enable_09 = 1'b1; enable_24 = 1'b1;
        n = 0;
        while (!((got_data.size() - base >= 12) && !busy) && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (got_data.size() - base !== 12) begin
            errors++;
            $display("[TB] FAIL rst_after_count: got %0d bytes expected 12", got_data.size() - base);
        end
        checks++;
        if (got_data.size() <= base || {got_chan[base], got_first[base], got_data[base]} !== {1'b0, 1'b1, 8'h99}) begin
            errors++;
            $display("[TB] FAIL rst_tie_09: first byte after reset not chan 0 first 1 data 99 (bytes seen %0d)",
                     got_data.size() - base);
        end
        enable_09 = 1'b0; enable_24 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_round_robin();
        test_ready_toggle();
        test_enable_drop();
        test_overflow();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
